// File: rtl/ddr_burst_reader_if.sv
// ddr_burst_reader_if: command, AXI4 read channel and output stream of the burst reader
interface ddr_burst_reader_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 256,
    parameter int LEN_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              done;
    logic              err;
    logic              m_axi_arid;
    logic [ADDR_W-1:0] m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic [2:0]        m_axi_arsize;
    logic [1:0]        m_axi_arburst;
    logic              m_axi_arlock;
    logic [3:0]        m_axi_arcache;
    logic [2:0]        m_axi_arprot;
    logic [3:0]        m_axi_arqos;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic              m_axi_rid;
    logic [DATA_W-1:0] m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rlast;
    logic              m_axi_rvalid;
    logic              m_axi_rready;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len,
        output cmd_ready, done, err,
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        output m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready,
        output out_valid, out_data, out_last,
        input  out_ready
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len,
        input  cmd_ready, done, err,
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        input  m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready,
        input  out_valid, out_data, out_last,
        output out_ready
    );
endinterface

// File: rtl/ddr_burst_reader.sv
// ddr_burst_reader: AXI4 INCR read-burst engine feeding a valid/ready beat stream
module ddr_burst_reader #(
    parameter int ADDR_W    = 30,
    parameter int DATA_W    = 256,
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = 16
) (
    input logic clk,
    input logic resetn,
    ddr_burst_reader_if.master bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int BSH   = $clog2(BYTES);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, FLUSH} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;
    logic [8:0]        beat_cnt, n, cap_rem, cap_bnd;
    logic [12:0]       bnd;
    logic [DATA_W-1:0] buf_data [2];
    logic [1:0]        buf_last;
    logic              wr_ptr, rd_ptr;
    logic [1:0]        count;
    logic              done_q, err_q;
    logic              cmd_ready, arvalid, rready, push, pop, last_beat;
    logic              unused_ok;

    // burst size: bounded by beats left, MAX_BURST and the next 4 KB page
    always_comb begin
        bnd     = (13'h1000 - {1'b0, cur_addr[11:0]}) >> BSH;
        cap_bnd = bnd > 13'(MAX_BURST) ? 9'(MAX_BURST) : 9'(bnd);
        cap_rem = remaining > LEN_W'(MAX_BURST) ? 9'(MAX_BURST) : 9'(remaining);
        n       = cap_rem < cap_bnd ? cap_rem : cap_bnd;
    end

    assign last_beat = beat_cnt == 9'd1;
    assign pop       = count != 2'd0 && bus.out_ready;
    assign push      = bus.m_axi_rvalid && rready;

    // next state and handshake strobes
    always_comb begin
        state_nx  = state;
        cmd_ready = state == IDLE;
        arvalid   = state == ADDR;
        rready    = state == DATA && (count != 2'd2 || pop);
        case (state)
            IDLE:    if (bus.cmd_valid) state_nx = bus.cmd_len == '0 ? FLUSH : ADDR;
            ADDR:    if (bus.m_axi_arready) state_nx = DATA;
            DATA:    if (push && last_beat) state_nx = remaining != '0 ? ADDR : FLUSH;
            FLUSH:   if (done_q) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else state <= state_nx;
    end

    // command latch, burst bookkeeping, sticky error and done pulse
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cur_addr  <= '0;
            remaining <= '0;
            beat_cnt  <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= state == FLUSH && count == 2'd0 && !done_q;
            if (state == IDLE && bus.cmd_valid) begin
                cur_addr  <= bus.cmd_addr & ~ADDR_W'(BYTES - 1);
                remaining <= bus.cmd_len;
                err_q     <= 1'b0;
            end
            if (state == ADDR && bus.m_axi_arready) begin
                beat_cnt  <= n;
                cur_addr  <= cur_addr + (ADDR_W'(n) << BSH);
                remaining <= remaining - LEN_W'(n);
            end
            if (push) begin
                beat_cnt <= beat_cnt - 9'd1;
                if (bus.m_axi_rresp != 2'b00) err_q <= 1'b1;
            end
        end
    end

    // two-entry output buffer; a push and a pop may share a cycle even when full
    always_ff @(posedge clk) begin
        if (!resetn) begin
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last    <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= bus.m_axi_rdata;
                buf_last[wr_ptr] <= remaining == '0 && last_beat;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign unused_ok         = ^{bus.m_axi_rid, bus.m_axi_rlast};
    assign bus.cmd_ready     = cmd_ready;
    assign bus.done          = done_q;
    assign bus.err           = err_q;
    assign bus.m_axi_arid    = 1'b0;
    assign bus.m_axi_araddr  = arvalid ? cur_addr : '0;
    assign bus.m_axi_arlen   = arvalid ? 8'(n - 9'd1) : 8'd0;
    assign bus.m_axi_arsize  = 3'(BSH);
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_arlock  = 1'b0;
    assign bus.m_axi_arcache = 4'b0011;
    assign bus.m_axi_arprot  = 3'd0;
    assign bus.m_axi_arqos   = 4'd0;
    assign bus.m_axi_arvalid = arvalid;
    assign bus.m_axi_rready  = rready;
    assign bus.out_valid     = count != 2'd0;
    assign bus.out_data      = buf_data[rd_ptr];
    assign bus.out_last      = count != 2'd0 && buf_last[rd_ptr];
endmodule

// File: tb/tb_ddr_burst_reader.sv
// tb_ddr_burst_reader: randomized AXI memory and stream sink checked against a beat/burst model
module tb_ddr_burst_reader;
    localparam int ADDR_W    = 30;
    localparam int DATA_W    = 256;
    localparam int MAX_BURST = 16;
    localparam int LEN_W     = 16;
    localparam int BYTES     = DATA_W / 8;
    localparam int AR_WAIT = 0, AR_HS = 1, R_WAIT = 2, R_HS = 3;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    ddr_burst_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bif();
    ddr_burst_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .LEN_W(LEN_W))
        dut (.clk(clk), .resetn(resetn), .bus(bif));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [DATA_W-1:0] exp_data [$];
    bit                exp_last [$];
    logic [ADDR_W+7:0] exp_ar [$];
    logic [ADDR_W+7:0] ar_log [$];
    logic [ADDR_W+7:0] ar_prev;
    int occ = 0, r_out = 0, hs_cyc = 0, done_cyc = 0;
    bit busy = 0, err_exp = 0, done_seen = 0, after_done = 0, ar_wait = 0;
    bit m_push, m_pop, m_err;
    logic [31:0] salt;
    bit or_rand = 0;
    int dmax = 0, err_beat = -1, gbeat = 0;
    int phase = AR_WAIT, scnt = 0, sbeat = 0;
    logic [ADDR_W-1:0] sa;
    logic [7:0] sl;
    bit hs_r = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] mem(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] w;
        for (int k = 0; k < DATA_W / 32; k++) w[k*32 +: 32] = (32'(a) * 32'h9E3779B1) ^ (32'(k) << 27) ^ salt;
        return w;
    endfunction

    // expected beats are just consecutive memory words; bursts follow the page/size rules
    task automatic expect_cmd(input logic [ADDR_W-1:0] addr, input int len);
        logic [ADDR_W-1:0] a;
        int rem, n, b;
        a = {addr[ADDR_W-1:5], 5'd0};
        for (int i = 0; i < len; i++) begin
            exp_data.push_back(mem(a + ADDR_W'(i * BYTES)));
            exp_last.push_back(i == len - 1);
        end
        rem = len;
        while (rem > 0) begin
            n = rem < MAX_BURST ? rem : MAX_BURST;
            b = (4096 - int'(a[11:0])) / BYTES;
            if (b < n) n = b;
            exp_ar.push_back({a, 8'(n - 1)});
            a = a + ADDR_W'(n * BYTES);
            rem = rem - n;
        end
    endtask

    task automatic chk_ar(input int i, input logic [ADDR_W-1:0] a, input logic [7:0] l);
        if (i < ar_log.size()) chk("ar_literal", ar_log[i], {a, l});
        else chk("ar_literal_missing", 0, 1);
    endtask

    task automatic chk_reset(input string nm);
        chk(nm, {bif.cmd_ready, bif.done, bif.err, bif.m_axi_arvalid, bif.m_axi_rready, bif.out_valid, bif.out_last}, 7'b1000000);
        chk(nm, {bif.m_axi_araddr, bif.m_axi_arlen}, '0);
        chk(nm, bif.out_data, '0);
    endtask

    task automatic run_cmd(input logic [ADDR_W-1:0] a, input int len, input bit junk);
        int t;
        @(negedge clk);
        t = 0;
        while (!bif.cmd_ready && t < 100) begin @(negedge clk); t++; end
        gbeat = 0;
        done_seen = 0;
        expect_cmd(a, len);
        bif.cmd_valid = 1'b1;
        bif.cmd_addr = a;
        bif.cmd_len = LEN_W'(len);
        @(negedge clk);
        if (junk) begin
            bif.cmd_addr = ~a;
            bif.cmd_len = 16'd5;
            repeat (4) @(negedge clk);
        end
        bif.cmd_valid = 1'b0;
        t = 0;
        while (!done_seen && t < 4000) begin @(negedge clk); t++; end
        chk("done_timeout", done_seen, 1);
        @(negedge clk);
    endtask

    // stream sink readiness
    initial begin
        bif.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            bif.out_ready = or_rand ? 1'($urandom % 2) : 1'b1;
        end
    end

    // AXI read slave: random AR and R latency, one burst at a time
    initial begin
        bif.m_axi_arready = 1'b0;
        bif.m_axi_rvalid = 1'b0;
        bif.m_axi_rdata = '0;
        bif.m_axi_rresp = 2'b00;
        bif.m_axi_rid = 1'b0;
        bif.m_axi_rlast = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!resetn) begin
                bif.m_axi_arready = 1'b0;
                bif.m_axi_rvalid = 1'b0;
                bif.m_axi_rresp = 2'b00;
                phase = AR_WAIT;
                scnt = 0;
                hs_r = 0;
                continue;
            end
            if (phase == R_HS && hs_r) begin
                bif.m_axi_rvalid = 1'b0;
                bif.m_axi_rresp = 2'b00;
                bif.m_axi_rlast = 1'b0;
                sbeat++;
                gbeat++;
                scnt = int'($urandom_range(dmax, 0));
                phase = sbeat > int'(sl) ? AR_WAIT : R_WAIT;
            end
            if (phase == AR_HS) begin
                bif.m_axi_arready = 1'b0;
                sbeat = 0;
                scnt = int'($urandom_range(dmax, 0));
                phase = R_WAIT;
            end
            if (phase == R_WAIT) begin
                if (scnt == 0) begin
                    bif.m_axi_rvalid = 1'b1;
                    bif.m_axi_rdata = mem(sa + ADDR_W'(sbeat * BYTES));
                    bif.m_axi_rresp = gbeat == err_beat ? 2'd2 : 2'd0;
                    bif.m_axi_rlast = sbeat == int'(sl);
                    phase = R_HS;
                end else scnt--;
            end else if (phase == AR_WAIT && bif.m_axi_arvalid) begin
                if (scnt == 0) begin
                    bif.m_axi_arready = 1'b1;
                    sa = bif.m_axi_araddr;
                    sl = bif.m_axi_arlen;
                    phase = AR_HS;
                end else scnt--;
            end
            hs_r = bif.m_axi_rvalid && bif.m_axi_rready;
        end
    end

    // compare process: every cycle, just before the rising edge
    initial begin
        forever begin
            @(negedge clk);
            #3;
            cyc++;
            if (!resetn) begin
                exp_data.delete();
                exp_last.delete();
                exp_ar.delete();
                occ = 0;
                r_out = 0;
                busy = 0;
                err_exp = 0;
                after_done = 0;
                ar_wait = 0;
                continue;
            end
            m_pop = bif.out_valid && bif.out_ready;
            m_push = bif.m_axi_rvalid && bif.m_axi_rready;
            m_err = err_exp;
            chk("out_valid", bif.out_valid, occ != 0);
            chk("err", bif.err, err_exp);
            if (occ == 2 && !m_pop) chk("rready_full", bif.m_axi_rready, 0);
            if (busy) chk("cmd_ready_busy", bif.cmd_ready, 0);
            if (after_done) begin
                chk("cmd_ready_after_done", bif.cmd_ready, 1);
                after_done = 0;
            end
            if (ar_wait && !bif.m_axi_arvalid) chk("arvalid_held", 0, 1);
            if (bif.m_axi_arvalid) begin
                chk("ar_single_outstanding", r_out, 0);
                chk("ar_consts", {bif.m_axi_arid, bif.m_axi_arsize, bif.m_axi_arburst, bif.m_axi_arlock,
                                  bif.m_axi_arcache, bif.m_axi_arprot, bif.m_axi_arqos},
                    {1'b0, 3'd5, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0});
                if (ar_wait) chk("ar_stable", {bif.m_axi_araddr, bif.m_axi_arlen}, ar_prev);
                ar_prev = {bif.m_axi_araddr, bif.m_axi_arlen};
                if (bif.m_axi_arready) begin
                    ar_log.push_back(ar_prev);
                    if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
                    else chk("ar", ar_prev, exp_ar.pop_front());
                    r_out += int'(bif.m_axi_arlen) + 1;
                end
            end
            ar_wait = bif.m_axi_arvalid && !bif.m_axi_arready;
            if (m_push) begin
                r_out--;
                occ++;
                if (bif.m_axi_rresp != 2'b00) m_err = 1;
            end
            if (m_pop) begin
                if (exp_data.size() == 0) chk("beat_unexpected", 1, 0);
                else begin
                    chk("beat_data", bif.out_data, exp_data.pop_front());
                    chk("beat_last", bif.out_last, exp_last.pop_front());
                end
                occ--;
            end
            if (bif.cmd_valid && bif.cmd_ready) begin
                busy = 1;
                hs_cyc = cyc;
                m_err = 0;
                ar_log.delete();
            end
            if (bif.done) begin
                chk("done_complete", {busy, exp_data.size() == 0, exp_ar.size() == 0}, 3'b111);
                busy = 0;
                done_seen = 1;
                done_cyc = cyc;
                after_done = 1;
            end
            err_exp = m_err;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [ADDR_W-1:0] ra;
        salt = $urandom;
        bif.cmd_valid = 1'b0;
        bif.cmd_addr = '0;
        bif.cmd_len = '0;
        repeat (2) @(negedge clk);
        #3;
        chk_reset("reset_values");
        @(negedge clk);
        resetn = 1'b1;

        run_cmd(30'h1000, 16, 0);
        chk("t1_ar_count", ar_log.size(), 1);
        chk_ar(0, 30'h1000, 8'd15);
        chk("t1_err", bif.err, 0);

        run_cmd(30'h1000, 40, 0);
        chk("t2_ar_count", ar_log.size(), 3);
        chk_ar(0, 30'h1000, 8'd15);
        chk_ar(1, 30'h1200, 8'd15);
        chk_ar(2, 30'h1400, 8'd7);

        run_cmd(30'h0FC0, 4, 0);
        chk("t3_ar_count", ar_log.size(), 2);
        chk_ar(0, 30'h0FC0, 8'd1);
        chk_ar(1, 30'h1000, 8'd1);

        run_cmd(30'h0FD3, 2, 0);
        chk_ar(0, 30'h0FC0, 8'd1);

        or_rand = 1;
        dmax = 5;
        ra = ADDR_W'($urandom_range(32'h3FFF, 0)) << 5;
        run_cmd(ra, 32, 1);

        run_cmd(30'h2040, 0, 0);
        chk("len0_done_latency", done_cyc - hs_cyc, 2);
        chk("len0_no_ar", ar_log.size(), 0);

        for (int i = 0; i < 6; i++) begin
            dmax = int'($urandom_range(5, 0));
            ra = ADDR_W'($urandom_range(32'h3FFF, 0)) << 5;
            run_cmd(ra, int'($urandom_range(80, 1)), 0);
        end

        err_beat = 2;
        run_cmd(30'h2000, 16, 0);
        chk("err_sticky", bif.err, 1);
        err_beat = -1;
        run_cmd(30'h2400, 8, 0);
        chk("err_cleared", bif.err, 0);

        or_rand = 0;
        dmax = 1;
        @(negedge clk);
        gbeat = 0;
        done_seen = 0;
        expect_cmd(30'h3000, 16);
        bif.cmd_valid = 1'b1;
        bif.cmd_addr = 30'h3000;
        bif.cmd_len = 16'd16;
        @(negedge clk);
        bif.cmd_valid = 1'b0;
        t = 0;
        while (exp_data.size() > 12 && t < 200) begin @(negedge clk); t++; end
        chk("reset_setup_timeout", t < 200, 1);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #3;
        chk_reset("reset_mid_data");
        run_cmd(30'h3000, 16, 0);
        chk("post_reset_ar_count", ar_log.size(), 1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
